// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: aluCtr opcodes, arbiter state, opcode legality.
// Latency: n/a (package only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SHL  = 4'b1000;
  localparam logic [3:0] ALU_SHR  = 4'b1001;
  localparam logic [3:0] ALU_PUSH = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } arb_state_t;

  // True for the eight opcodes the ALU implements; anything else is squashed at latch time.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_SHL, ALU_SHR, ALU_PUSH: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Two-way grant picker; ALU_ARB_RR_EN selects round-robin, otherwise port 0 wins ties.
// Latency: combinational.
// Backpressure: none; grants only among eligible ports, one-hot or zero.
module alu_arb_pick (
  input  logic [1:0] i_eligible,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // Single eligible port always wins; a tie is resolved by the configured policy.
  always_comb begin
    o_grant = i_eligible;
    if (i_eligible == 2'b11) begin
`ifdef ALU_ARB_RR_EN
      o_grant = i_last_grant ? 2'b01 : 2'b10;
`else
      o_grant = 2'b01;
`endif
    end
  end

`ifndef ALU_ARB_RR_EN
  // Fixed priority has no history; the input is kept so the port list is mode-independent.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two requesters; ALU_ARB_RR_EN enables round-robin ties.
// Latency: accept at t, ALU evaluates at t+1, rspN_valid from t+2; one op per 2 cycles.
// Backpressure: a port with an unconsumed response is not granted; the other port proceeds.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [3:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [4:0]    req0_shamt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [3:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [4:0]    req1_shamt,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_result,
  output logic          rsp0_zero,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_result,
  output logic          rsp1_zero,
  output logic [DW-1:0] alu_oprend1,
  output logic [DW-1:0] alu_oprend2,
  output logic [3:0]    alu_ctr,
  output logic [4:0]    alu_shamt,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero
);

  arb_state_t    r_state;
  logic          r_owner;
  logic [1:0]    r_rsp_vld;
  logic [DW-1:0] r_rsp0_result;
  logic [DW-1:0] r_rsp1_result;
  logic          r_rsp0_zero;
  logic          r_rsp1_zero;
  logic [DW-1:0] r_alu_op1;
  logic [DW-1:0] r_alu_op2;
  logic [3:0]    r_alu_ctr;
  logic [4:0]    r_alu_shamt;

  logic [1:0]    w_eligible;
  logic [1:0]    w_grant;
  logic [1:0]    w_accept;
  logic          w_last_grant;
  logic          w_win;
  logic          w_legal;
  logic [3:0]    w_op;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [4:0]    w_shamt;

`ifdef ALU_ARB_RR_EN
  logic          r_last_grant;
  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = 1'b1;
`endif

  // A pending response blocks only its own port.
  assign w_eligible = {req1_valid & ~r_rsp_vld[1], req0_valid & ~r_rsp_vld[0]};

  alu_arb_pick u_pick (
    .i_eligible   (w_eligible),
    .i_last_grant (w_last_grant),
    .o_grant      (w_grant)
  );

  // Grants are only issued in IDLE and never while reset is asserted.
  assign w_accept   = (rst_n && (r_state == IDLE)) ? w_grant : 2'b00;
  assign req0_ready = w_accept[0];
  assign req1_ready = w_accept[1];

  assign w_win   = w_accept[1];
  assign w_op    = w_win ? req1_op    : req0_op;
  assign w_a     = w_win ? req1_a     : req0_a;
  assign w_b     = w_win ? req1_b     : req0_b;
  assign w_shamt = w_win ? req1_shamt : req0_shamt;
  assign w_legal = is_legal_op(w_op);

  // Arbiter FSM: latch winner's operands in IDLE, capture ALU output into owner's response in EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_rsp_vld     <= 2'b00;
      r_rsp0_result <= '0;
      r_rsp1_result <= '0;
      r_rsp0_zero   <= 1'b0;
      r_rsp1_zero   <= 1'b0;
      r_alu_op1     <= '0;
      r_alu_op2     <= '0;
      r_alu_ctr     <= ALU_AND;
      r_alu_shamt   <= '0;
`ifdef ALU_ARB_RR_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      if (r_rsp_vld[0] && rsp0_ready) r_rsp_vld[0] <= 1'b0;
      if (r_rsp_vld[1] && rsp1_ready) r_rsp_vld[1] <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_accept) begin
            // Illegal opcodes become AND with a zero operand so the result is a clean 0.
            r_alu_ctr    <= w_legal ? w_op : ALU_AND;
            r_alu_op1    <= w_a;
            r_alu_op2    <= w_legal ? w_b : '0;
            r_alu_shamt  <= w_shamt;
            r_owner      <= w_win;
`ifdef ALU_ARB_RR_EN
            r_last_grant <= w_win;
`endif
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          if (r_owner) begin
            r_rsp1_result <= alu_result;
            r_rsp1_zero   <= alu_zero;
          end else begin
            r_rsp0_result <= alu_result;
            r_rsp0_zero   <= alu_zero;
          end
          r_rsp_vld[r_owner] <= 1'b1;
          r_state            <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp0_valid  = r_rsp_vld[0];
  assign rsp1_valid  = r_rsp_vld[1];
  assign rsp0_result = r_rsp0_result;
  assign rsp1_result = r_rsp1_result;
  assign rsp0_zero   = r_rsp0_zero;
  assign rsp1_zero   = r_rsp1_zero;
  assign alu_oprend1 = r_alu_op1;
  assign alu_oprend2 = r_alu_op2;
  assign alu_ctr     = r_alu_ctr;
  assign alu_shamt   = r_alu_shamt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then randomized traffic vs a reference model.
// Latency: model predicts accept/EXEC/response timing from the documented rules.
// Backpressure: random rspN_ready exercises blocked ports.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  t_vld;
  logic [3:0]  t_op [2];
  logic [31:0] t_a  [2];
  logic [31:0] t_b  [2];
  logic [4:0]  t_sh [2];
  logic [1:0]  t_rrdy;

  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_oprend1, alu_oprend2, alu_result;
  logic [3:0]  alu_ctr;
  logic [4:0]  alu_shamt;
  logic        alu_zero;

  alu_arbiter #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t_vld[0]), .req0_ready(req0_ready), .req0_op(t_op[0]),
    .req0_a(t_a[0]), .req0_b(t_b[0]), .req0_shamt(t_sh[0]),
    .req1_valid(t_vld[1]), .req1_ready(req1_ready), .req1_op(t_op[1]),
    .req1_a(t_a[1]), .req1_b(t_b[1]), .req1_shamt(t_sh[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(t_rrdy[0]), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(t_rrdy[1]), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_oprend1(alu_oprend1), .alu_oprend2(alu_oprend2), .alu_ctr(alu_ctr), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Environment ALU fed by the arbiter's registered operands.
  always_comb begin
    alu_result = '0;
    case (alu_ctr)
      ALU_AND:  alu_result = alu_oprend1 & alu_oprend2;
      ALU_OR:   alu_result = alu_oprend1 | alu_oprend2;
      ALU_ADD:  alu_result = alu_oprend1 + alu_oprend2;
      ALU_SUB:  alu_result = alu_oprend1 - alu_oprend2;
      ALU_SLT:  alu_result = {31'b0, $signed(alu_oprend1) < $signed(alu_oprend2)};
      ALU_SHL:  alu_result = alu_oprend2 << alu_shamt;
      ALU_SHR:  alu_result = alu_oprend2 >> alu_shamt;
      ALU_PUSH: alu_result = alu_oprend2;
      default:  alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  legal_tbl [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1010, 4'b1000, 4'b1001, 4'b1100};

  bit          m_busy;
  int          m_owner;
  bit          m_last;
  bit  [1:0]   m_rv;
  bit  [1:0]   m_acc;
  logic [31:0] m_res [2];
  bit          m_z [2];
  logic [31:0] m_pres;
  logic [3:0]  m_ctr;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_sh;

  function automatic bit ref_legal(input logic [3:0] op);
    foreach (legal_tbl[i]) if (legal_tbl[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh);
    int signed sa, sb;
    if (!ref_legal(op)) return 32'd0;
    sa = a; sb = b;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a - b;
      4'b1010: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: return b * (32'd1 << sh);
      4'b1001: return b / (32'd1 << sh);
      default: return b;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1; m_rv = 0; m_acc = 0;
    m_res[0] = 0; m_res[1] = 0; m_z[0] = 0; m_z[1] = 0;
    m_pres = 0; m_ctr = 0; m_op1 = 0; m_op2 = 0; m_sh = 0;
  endtask

  // Which port should be granted this cycle (-1 for none).
  function automatic int exp_winner();
    bit [1:0] el;
    if (!rst_n || m_busy) return -1;
    el = t_vld & ~m_rv;
    if (el == 2'b00) return -1;
    if (el == 2'b01) return 0;
    if (el == 2'b10) return 1;
`ifdef ALU_ARB_RR_EN
    return m_last ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_check();
    int w = exp_winner();
    chk("req0_ready",  {31'b0, req0_ready}, {31'b0, w == 0});
    chk("req1_ready",  {31'b0, req1_ready}, {31'b0, w == 1});
    chk("rsp0_valid",  {31'b0, rsp0_valid}, {31'b0, m_rv[0]});
    chk("rsp1_valid",  {31'b0, rsp1_valid}, {31'b0, m_rv[1]});
    chk("rsp0_result", rsp0_result, m_res[0]);
    chk("rsp1_result", rsp1_result, m_res[1]);
    chk("rsp0_zero",   {31'b0, rsp0_zero}, {31'b0, m_z[0]});
    chk("rsp1_zero",   {31'b0, rsp1_zero}, {31'b0, m_z[1]});
    chk("alu_ctr",     {28'b0, alu_ctr}, {28'b0, m_ctr});
    chk("alu_oprend1", alu_oprend1, m_op1);
    chk("alu_oprend2", alu_oprend2, m_op2);
    chk("alu_shamt",   {27'b0, alu_shamt}, {27'b0, m_sh});
  endtask

  task automatic model_advance();
    int w = exp_winner();
    bit lg;
    m_acc = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int n = 0; n < 2; n++) if (m_rv[n] && t_rrdy[n]) m_rv[n] = 0;
    if (m_busy) begin
      m_rv[m_owner]  = 1;
      m_res[m_owner] = m_pres;
      m_z[m_owner]   = (m_pres == 0);
      m_busy = 0;
    end else if (w >= 0) begin
      lg = ref_legal(t_op[w]);
      m_acc[w] = 1;
      m_busy   = 1;
      m_owner  = w;
      m_last   = (w == 1);
      m_pres   = ref_calc(t_op[w], t_a[w], t_b[w], t_sh[w]);
      m_ctr    = lg ? t_op[w] : 4'b0000;
      m_op1    = t_a[w];
      m_op2    = lg ? t_b[w] : 32'd0;
      m_sh     = t_sh[w];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick_adv();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick_check();
    tick_adv();
  endtask

  task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
    t_vld[n] = 1'b1; t_op[n] = op; t_a[n] = a; t_b[n] = b; t_sh[n] = sh;
  endtask

  task automatic new_req(input int n);
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    if ($urandom_range(0, 5) == 0) op = 4'($urandom);
    else op = legal_tbl[$urandom_range(0, 7)];
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    sh = 5'($urandom);
    set_req(n, op, a, b, sh);
  endtask

  // Requesters hold valid until accepted, then issue a new op or go idle.
  task automatic drive_random();
    for (int n = 0; n < 2; n++) begin
      if (t_vld[n]) begin
        if (m_acc[n]) begin
          if ($urandom_range(0, 2) != 0) new_req(n);
          else t_vld[n] = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        new_req(n);
      end
      t_rrdy[n] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    bit got;
    rst_n = 1'b0; t_vld = 2'b00; t_rrdy = 2'b00;
    for (int n = 0; n < 2; n++) begin
      t_op[n] = 0; t_a[n] = 0; t_b[n] = 0; t_sh[n] = 0;
    end
    model_reset();
    @(posedge clk); #1;

    // Reset values.
    tick_check();
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    chk("rst_alu_ctr", {28'b0, alu_ctr}, 32'd0);
    tick_adv();
    step();
    rst_n = 1'b1;
    step();

    // Single ADD request on port 0.
    set_req(0, ALU_ADD, 32'd5, 32'd7, 5'd0);
    tick_check();
    chk("add_ready0", {31'b0, req0_ready}, 32'd1);
    tick_adv();
    t_vld[0] = 1'b0;
    tick_check();
    chk("add_alu_ctr", {28'b0, alu_ctr}, 32'b0010);
    tick_adv();
    tick_check();
    chk("add_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("add_rsp0_result", rsp0_result, 32'd12);
    chk("add_rsp0_zero", {31'b0, rsp0_zero}, 32'd0);
    tick_adv();

    // SUB producing zero on port 1; port 0 response untouched.
    set_req(1, ALU_SUB, 32'd9, 32'd9, 5'd0);
    tick_check();
    chk("sub_ready1", {31'b0, req1_ready}, 32'd1);
    tick_adv();
    t_vld[1] = 1'b0;
    step();
    tick_check();
    chk("sub_rsp1_result", rsp1_result, 32'd0);
    chk("sub_rsp1_zero", {31'b0, rsp1_zero}, 32'd1);
    chk("sub_rsp0_result", rsp0_result, 32'd12);
    chk("sub_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    tick_adv();

    // Backpressure: port 0 blocked by its pending response while port 1 keeps shifting.
    set_req(0, ALU_ADD, 32'd1, 32'd1, 5'd0);
    set_req(1, ALU_SHL, 32'd0, 32'd1, 5'd4);
    t_rrdy = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick_check();
      chk("bp_no_grant0", {31'b0, req0_ready}, 32'd0);
      tick_adv();
    end
    tick_check();
    chk("bp_shl_result", rsp1_result, 32'd16);
    tick_adv();
    t_rrdy = 2'b11;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick_check();
      if (req0_ready) got = 1'b1;
      tick_adv();
      if (got) t_vld[0] = 1'b0;
    end
    chk("bp_release0", {31'b0, got}, 32'd1);
    t_vld[1] = 1'b0;
    repeat (6) step();

    // Illegal opcode is squashed to AND with zero operand.
    set_req(0, 4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    tick_check();
    chk("ill_ready0", {31'b0, req0_ready}, 32'd1);
    tick_adv();
    t_vld[0] = 1'b0;
    tick_check();
    chk("ill_alu_ctr", {28'b0, alu_ctr}, 32'd0);
    chk("ill_alu_oprend2", alu_oprend2, 32'd0);
    tick_adv();
    tick_check();
    chk("ill_rsp0_result", rsp0_result, 32'd0);
    chk("ill_rsp0_zero", {31'b0, rsp0_zero}, 32'd1);
    tick_adv();
    repeat (2) step();

    // Reset during EXEC discards the op; the following tie goes to port 0.
    set_req(0, ALU_ADD, 32'd3, 32'd4, 5'd0);
    tick_check();
    chk("mr_ready0", {31'b0, req0_ready}, 32'd1);
    tick_adv();
    t_vld[0] = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, ALU_OR, 32'h00F0, 32'h0F00, 5'd0);
    set_req(1, ALU_AND, 32'h1234, 32'hFFFF, 5'd0);
    tick_check();
    chk("mr_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("mr_rsp0_result", rsp0_result, 32'd0);
    chk("mr_alu_ctr", {28'b0, alu_ctr}, 32'd0);
    chk("mr_tie_ready0", {31'b0, req0_ready}, 32'd1);
    chk("mr_tie_ready1", {31'b0, req1_ready}, 32'd0);
    tick_adv();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
